// File: rtl/ps2_pkg.sv
// Shared definitions for the keyboard-side PS/2 transmitter: FSM state
// codes, frame constants and the parity helper.
package ps2_pkg;

    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t IDLE   = 3'd0;
    localparam ps2_state_t LOAD   = 3'd1;
    localparam ps2_state_t BIT_HI = 3'd2;
    localparam ps2_state_t BIT_LO = 3'd3;
    localparam ps2_state_t GAP    = 3'd4;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Odd parity: the bit that makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small first-word-fallthrough byte FIFO feeding the PS/2 serialiser.
// dout always shows the head entry while the FIFO is non-empty.
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// Keyboard-side PS/2 transmitter: buffers scan-code bytes and sends each as
// an 11-bit device-to-host frame (start, d0..d7, odd parity, stop).
// Optional host-inhibit detection/retransmit: define PS2_DEVICE_TX_INHIBIT_EN.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] scan_code,
    input  logic       key_action,
`ifdef PS2_DEVICE_TX_INHIBIT_EN
    input  logic       ps2_clk_in,
`endif
    output logic       ps2_clk,
    output logic       ps2_dat,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int CMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE   = CW'(2);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

    ps2_state_t    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    shreg;
    logic          retry;

    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_pop;
    logic [AW:0]   fifo_count;

    logic          hp_done;
    logic          gap_done;
    logic          inhibit;
    logic          line_high;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (Resetn),
        .push  (key_action),
        .din   (scan_code),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign hp_done = (cnt == HP_LAST);
    // GAP itself is 2 cycles short: the IDLE and LOAD cycles that follow
    // keep both lines high, so the idle stretch totals GAP_CYCLES.
    assign gap_done = (int'(cnt) + 3 >= GAP_CYCLES);

`ifdef PS2_DEVICE_TX_INHIBIT_EN
    logic [1:0] clk_sync;

    // Two-flop synchroniser for the sensed clock line.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) clk_sync <= 2'b11;
        else         clk_sync <= {clk_sync[0], ps2_clk_in};
    end

    assign line_high = clk_sync[1];
    // Host pulling the clock low while we release it (after settling) in bits 0..9.
    assign inhibit   = (state == BIT_HI) && (bit_idx < LAST_BIT) &&
                       (cnt >= SETTLE) && !clk_sync[1];
    // Byte stays at the FIFO head until the stop bit starts, so an abort can retry it.
    assign fifo_pop  = (state == BIT_LO) && hp_done && (bit_idx == LAST_BIT - 4'd1);
`else
    assign line_high = 1'b1;
    assign inhibit   = 1'b0;
    assign fifo_pop  = (state == LOAD);
`endif

    assign busy = (state != IDLE) || (fifo_count != '0);
    assign full = fifo_full;

    // Dropped-write indicator, high for the cycle after a strobe into a full FIFO.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) overflow <= 1'b0;
        else         overflow <= key_action && fifo_full;
    end

    // Frame sequencer: each bit is a HIGH phase (data updated) then a LOW phase.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            retry   <= 1'b0;
            ps2_clk <= 1'b1;
            ps2_dat <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    shreg   <= {STOP_BIT, odd_parity(fifo_dout), fifo_dout};
                    ps2_dat <= START_BIT;
                    ps2_clk <= 1'b1;
                    bit_idx <= '0;
                    cnt     <= '0;
                    state   <= BIT_HI;
                end
                BIT_HI: begin
                    if (inhibit) begin
                        ps2_dat <= 1'b1;
                        retry   <= 1'b1;
                        cnt     <= '0;
                        state   <= GAP;
                    end else if (hp_done) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b0;
                        state   <= BIT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_LO: begin
                    if (hp_done) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            ps2_dat <= 1'b1;
                            state   <= GAP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            ps2_dat <= shreg[0];
                            shreg   <= {1'b1, shreg[9:1]};
                            state   <= BIT_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (retry) begin
                        // After an abort, wait for GAP_CYCLES of continuous high clock line.
                        if (!line_high) begin
                            cnt <= '0;
                        end else if (cnt == GAP_LAST) begin
                            cnt   <= '0;
                            retry <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (gap_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: decodes frames off the PS/2 lines
// at each clock fall and compares them with frames built from the byte rules.
`timescale 1ns/1ps
module tb_ps2_device_tx;
    localparam int HP    = 4;
    localparam int GAP   = 6;
    localparam int DEPTH = 4;
`ifdef PS2_DEVICE_TX_INHIBIT_EN
    localparam int BURST_MAX = 4;
    localparam int POP_EDGE  = -1;
`else
    localparam int BURST_MAX = 5;
    localparam int POP_EDGE  = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       key_action = 1'b0;
    logic       ps2_clk, ps2_dat, busy, full, overflow;
`ifdef PS2_DEVICE_TX_INHIBIT_EN
    logic       host_low = 1'b0;
    logic       ps2_clk_in;
    assign ps2_clk_in = ps2_clk & ~host_low;
`endif

    ps2_device_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50   (clk),
        .Resetn     (rst_n),
        .scan_code  (scan_code),
        .key_action (key_action),
`ifdef PS2_DEVICE_TX_INHIBIT_EN
        .ps2_clk_in (ps2_clk_in),
`endif
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .busy       (busy),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    logic        prev_clk = 1'b1;
    logic        prev_dat = 1'b1;
    logic [10:0] sh_bits = '0;
    int          nbits = 0;
    int          falls = 0;
    int          idle_run = 0;
    int          ovf_cnt = 0;
    int          clr_req = 0;
    int          clr_ack = 0;
    logic [10:0] rxq[$];
    int          idleq[$];

    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            nbits   = 0;
            clr_ack = clr_req;
        end
        if (prev_clk && !ps2_clk) begin
            if (nbits < 11) sh_bits[nbits] = ps2_dat;
            nbits++;
            falls++;
            if (nbits == 11) begin
                rxq.push_back(sh_bits);
                nbits = 0;
            end
        end
        if (ps2_clk && prev_dat && !ps2_dat && idle_run > 0) idleq.push_back(idle_run);
        idle_run = (ps2_clk && ps2_dat) ? idle_run + 1 : 0;
        if (overflow) ovf_cnt++;
        prev_clk = ps2_clk;
        prev_dat = ps2_dat;
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        // bit0 start=0, bits1..8 data LSB first, bit9 parity making total ones odd, bit10 stop=1
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    int rx_rd = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] b);
        scan_code  = b;
        key_action = 1'b1;
        @(negedge clk);
        key_action = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (busy && t < budget) begin
            step(1);
            t++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        step(2);
    endtask

    task automatic expect_frame(input string tag, input logic [10:0] exp);
        if (rx_rd < rxq.size()) begin
            chk(tag, 32'(rxq[rx_rd]), 32'(exp));
            rx_rd++;
        end else begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    logic [7:0] expq[$];
    logic [7:0] bytes6 [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, f0, f1, occ, r0, n;
        logic drop;

        #1 rst_n = 1'b0;
        step(3);
        chk("rst_clk",  32'(ps2_clk), 32'd1);
        chk("rst_dat",  32'(ps2_dat), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Single byte: latency, first fall, busy length, bit pattern
        f0 = falls;
        strobe(8'h1C);
        chk("busy_push", 32'(busy), 32'd1);
        step(1);
        chk("dat_n1", 32'(ps2_dat), 32'd1);
        step(1);
        chk("start_n2", 32'(ps2_dat), 32'd0);
        chk("clk_n2", 32'(ps2_clk), 32'd1);
        step(HP - 1);
        chk("clk_hi_end", 32'(ps2_clk), 32'd1);
        step(1);
        chk("first_fall", 32'(ps2_clk), 32'd0);
        t = 2 + HP;
        while (busy && t < 400) begin
            step(1);
            t++;
        end
        chk("busy_cycles", 32'(t), 32'd94);
        chk("falls_1C", 32'(falls - f0), 32'd11);
        expect_frame("frame_1C", 11'b100_0011_1000);

        // Parity corner bytes
        strobe(8'h00); wait_idle("p00", 400);
        expect_frame("frame_00", frame_of(8'h00));
        if (rx_rd > 0) chk("par_00", 32'(rxq[rx_rd-1][9]), 32'd1);
        strobe(8'hFF); wait_idle("pFF", 400);
        expect_frame("frame_FF", frame_of(8'hFF));
        if (rx_rd > 0) chk("par_FF", 32'(rxq[rx_rd-1][9]), 32'd1);
        strobe(8'h01); wait_idle("p01", 400);
        expect_frame("frame_01", frame_of(8'h01));
        if (rx_rd > 0) chk("par_01", 32'(rxq[rx_rd-1][9]), 32'd0);

        // Break code burst: back-to-back frames with exactly GAP idle cycles
        strobe(8'hF0);
        strobe(8'h1C);
        wait_idle("burst", 800);
        expect_frame("burst_F0", frame_of(8'hF0));
        expect_frame("burst_1C", frame_of(8'h1C));
        if (idleq.size() > 0) chk("burst_gap", 32'(idleq[$]), 32'(GAP));
        else chk("burst_gap_missing", 32'd0, 32'd1);

        // Overflow: six consecutive strobes into a 4-deep FIFO
        occ = 0;
        f0 = ovf_cnt;
        for (int k = 0; k < 6; k++) begin
            bytes6[k]  = 8'($urandom);
            scan_code  = bytes6[k];
            key_action = 1'b1;
            step(1);
            drop = (occ == DEPTH);
            if (!drop) begin
                occ++;
                expq.push_back(bytes6[k]);
            end
            if (k == POP_EDGE) occ--;
            chk($sformatf("ovf_%0d", k), 32'(overflow), 32'(drop));
            chk($sformatf("full_%0d", k), 32'(full), 32'(occ == DEPTH));
        end
        key_action = 1'b0;
        step(1);
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
        chk("ovf_pulses", 32'(ovf_cnt - f0), 32'(6 - expq.size()));
        wait_idle("ovf", 3000);
        while (expq.size() > 0) expect_frame("ovf_frame", frame_of(expq.pop_front()));

        // Random bursts small enough never to overflow
        f0 = ovf_cnt;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, BURST_MAX);
            for (int i = 0; i < n; i++) begin
                expq.push_back(8'($urandom));
                strobe(expq[$]);
                step($urandom_range(0, 2));
            end
            wait_idle("rand", 3000);
            while (expq.size() > 0) expect_frame("rand_frame", frame_of(expq.pop_front()));
        end
        chk("rand_no_ovf", 32'(ovf_cnt - f0), 32'd0);

        // Asynchronous reset during data bit 3
        f0 = falls;
        strobe(8'h5A);
        strobe(8'h33);
        t = 0;
        while (falls < f0 + 5 && t < 300) begin
            step(1);
            t++;
        end
        chk("mid_reach", 32'(falls >= f0 + 5), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_clk",  32'(ps2_clk), 32'd1);
        chk("mid_rst_dat",  32'(ps2_dat), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clr_req++;
        f1 = falls;
        r0 = rxq.size();
        step(300);
        chk("post_rst_falls", 32'(falls - f1), 32'd0);
        chk("post_rst_frames", 32'(rxq.size() - r0), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef PS2_DEVICE_TX_INHIBIT_EN
        // Host inhibit during bit 5, then full retransmit
        f0 = falls;
        strobe(8'h1C);
        t = 0;
        while (falls < f0 + 5 && t < 300) begin
            step(1);
            t++;
        end
        t = 0;
        while (!ps2_clk && t < 20) begin
            step(1);
            t++;
        end
        chk("inh_reach", 32'(ps2_clk), 32'd1);
        host_low = 1'b1;
        f1 = falls;
        step(10);
        chk("inh_clk",   32'(ps2_clk), 32'd1);
        chk("inh_dat",   32'(ps2_dat), 32'd1);
        chk("inh_busy",  32'(busy), 32'd1);
        chk("inh_falls", 32'(falls - f1), 32'd0);
        host_low = 1'b0;
        clr_req++;
        t = 0;
        while (ps2_dat && t < 200) begin
            step(1);
            t++;
        end
        chk("inh_wait", 32'(t >= GAP && t <= GAP + 6), 32'd1);
        wait_idle("inh", 400);
        expect_frame("inh_frame", frame_of(8'h1C));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Keyboard-side PS/2 transmitter. Accepts scan-code bytes on a one-cycle strobe, buffers them in a small FIFO, and serialises each byte as an 11-bit PS/2 device-to-host frame on ps2_clk/ps2_dat.
- Drives the keyboard-side PS/2 pins in DE-series designs, feeding the host PS/2 receiver used by demo Top modules. Also lets benches emulate a keyboard without the simulator's keyboard path.

Parameters:
- HALF_PERIOD, 2500: CLOCK_50 cycles per PS/2 clock half-period (2500 gives 10 kHz). Minimum 2.
- GAP_CYCLES, 5000: idle CLOCK_50 cycles (both lines high) enforced after each stop bit. Minimum 1.
- FIFO_DEPTH, 8: byte buffer depth. Power of two, 2..16.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous active-low reset
- scan_code  in  8  byte to send
- key_action  in  1  one-cycle write strobe for scan_code
- ps2_clk  out  1  PS/2 clock line (idle 1)
- ps2_dat  out  1  PS/2 data line (idle 1)
- busy  out  1  frame in progress or FIFO non-empty
- full  out  1  FIFO full
- overflow  out  1  one-cycle pulse when a strobe is dropped

Behaviour:
- Reset (asynchronous, Resetn=0): ps2_clk=1, ps2_dat=1, busy=0, full=0, overflow=0. FIFO is emptied, state=IDLE, counters=0. Asserting reset mid-frame aborts the frame immediately.
- Write: on a CLOCK_50 edge with key_action=1:
  - If !full, scan_code is pushed.
  - If full, the byte is dropped and overflow=1 for that next cycle only.
  - A push and a pop in the same cycle are both honoured.
- Frame: start 0, data bits d0..d7 (LSB first), odd parity (~^data), stop 1. 11 bits total.
- Each bit has two phases:
  - HIGH phase: ps2_clk=1 for HALF_PERIOD cycles. ps2_dat is updated on the first cycle of this phase.
  - LOW phase: ps2_clk=0 for HALF_PERIOD cycles.
  - The host samples on the falling edge, so data is stable for HALF_PERIOD cycles before every fall.
- States:
  - IDLE: waits for FIFO non-empty.
  - LOAD: pops the FIFO head into the shift register and computes parity.
  - BIT_HI / BIT_LO: alternate, with bit index 0..10.
  - GAP: after the LOW phase of bit 10, counts GAP_CYCLES, then returns to IDLE. If the FIFO is non-empty it goes straight on to LOAD.
- Latency: from IDLE with an empty FIFO, a key_action sampled at edge N produces ps2_dat=0 (start bit) after edge N+2. The first ps2_clk fall follows after edge N+2+HALF_PERIOD.
- Frame length is 22*HALF_PERIOD cycles, plus GAP_CYCLES before the next frame can start.
- busy=1 from the edge that makes the FIFO non-empty until GAP completes with the FIFO empty.
- full asserts when count==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Outputs are registered; no combinational path from inputs to ps2_clk/ps2_dat.

Optional Feature:
- Macro PS2_DEVICE_TX_INHIBIT_EN.
- When defined:
  - Adds input port ps2_clk_in (1 bit; the sensed line, wired-AND with host drive).
  - If ps2_clk_in=0 while the block drives ps2_clk=1 during BIT_HI of bits 0..9 (after a 2-cycle settle), the frame aborts. Both lines return to 1, and the byte is retained at the FIFO head, not popped.
  - The block waits until ps2_clk_in has been 1 for GAP_CYCLES, then retransmits the byte from its start bit.
  - Inhibit during bit 10 or GAP is ignored.
- When undefined: no ps2_clk_in port, and frames always complete.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, LOAD, BIT_HI, BIT_LO, GAP}
  - constants FRAME_BITS=11, START_BIT=0, STOP_BIT=1
  - function odd_parity(byte)
- One sub-module, ps2_tx_fifo (parameter DEPTH). Ports: push, din, pop, dout, full, empty, count. First-word-fallthrough.

Test Plan:
- Single byte: HALF_PERIOD=4, GAP_CYCLES=6, scan_code=0x1C strobed once. Expect:
  - Bits 0,0,0,1,1,1,0,0,0,0,1 sampled at 11 ps2_clk falls.
  - Start bit 2 cycles after the strobe; busy falls 94 cycles after the strobe.
- Parity: bytes 0x00 and 0xFF. Expect parity bit 1 for 0x00 and 1 for 0xFF; byte 0x01 gives parity 0.
- Burst/break code: strobe 0xF0 then 0x1C on consecutive cycles. Expect two back-to-back frames separated by exactly GAP_CYCLES of idle-high lines.
- Overflow: FIFO_DEPTH=4, 6 strobes on consecutive cycles while idle. Expect:
  - First byte popped into the shifter, the next 4 buffered, full=1.
  - The 6th strobe is dropped, with overflow pulsed for exactly 1 cycle.
  - 5 frames sent in order.
- Reset mid-frame: Resetn=0 during data bit 3. Expect ps2_clk=ps2_dat=1 and busy=0 asynchronously, and no further frames after release.
- PS2_DEVICE_TX_INHIBIT_EN: hold ps2_clk_in=0 during bit 5 of 0x1C. Expect abort, lines high, and a full retransmit of 0x1C after ps2_clk_in has been high for GAP_CYCLES.
